// File: rtl/wb_pkg.sv
// Shared Wishbone slave definitions: state encoding, bus widths and the byte-lane mask helper.
package wb_pkg;

   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;
   localparam int TAG_W  = 4;

   typedef logic [1:0] wb_state_t;

   localparam wb_state_t ST_IDLE = 2'd0;
   localparam wb_state_t ST_WAIT = 2'd1;
   localparam wb_state_t ST_TERM = 2'd2;

   // Expands each SEL bit into a full byte of the write mask, lane 0 = bits [7:0].
   function automatic logic [DATA_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int b = 0; b < SEL_W; b++) begin
         m[8*b +: 8] = {8{sel[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_slave_ram_mem.sv
// Byte-enable word storage for wb_slave_ram: synchronous masked write, asynchronous read.
module wb_slave_ram_mem
   import wb_pkg::*;
#(
   parameter int AW = 6
) (
   input  logic              clk_sys,
   input  logic              we,
   input  logic [SEL_W-1:0]  sel,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**AW];
   logic [DATA_W-1:0] mask;

   assign mask  = lane_mask(sel);
   assign rdata = mem[addr];

   // Contents are deliberately not reset; only the write strobe is gated by reset upstream.
   always_ff @(posedge clk_sys) begin
      if (we) begin
         mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
      end
   end

endmodule

// File: rtl/wb_slave_ram.sv
// Wishbone classic slave RAM with programmable wait states and address-range checking.
// Optional macro WB_SLAVE_RTY_EN adds LOCK_I and retry terminations; otherwise RTY_O is 0.
//
// state   | meaning
// IDLE    | waiting for CYC_I&STB_I; request fields captured on acceptance
// WAIT    | counting down wait states
// TERM    | issues ACK/ERR/RTY (visible next cycle) and commits any write
module wb_slave_ram
   import wb_pkg::*;
#(
   parameter int          AW          = 6,
   parameter logic [31:0] BASE        = 32'h4000_0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic              CLK_I,
   input  logic              RST_I,
   input  logic              CYC_I,
   input  logic              STB_I,
   input  logic              WE_I,
   input  logic [31:0]       ADR_I,
   input  logic [SEL_W-1:0]  SEL_I,
   input  logic [DATA_W-1:0] DAT_I,
   input  logic [TAG_W-1:0]  TAG_I,
`ifdef WB_SLAVE_RTY_EN
   input  logic              LOCK_I,
`endif
   output logic [DATA_W-1:0] DAT_O,
   output logic              ACK_O,
   output logic              ERR_O,
   output logic              RTY_O,
   output logic [TAG_W-1:0]  TAG_O
);

   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   wb_state_t         state;
   logic [3:0]        wait_cnt;
   logic [29:0]       adr_q;
   logic              we_q;
   logic [SEL_W-1:0]  sel_q;
   logic [DATA_W-1:0] dat_q;
   logic              ack_q;
   logic              err_q;
   logic              rty_q;

   logic              req;
   logic              busy;
   logic              in_range;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   assign req      = CYC_I & STB_I;
   assign in_range = (adr_q[29:AW] == BASE[31:AW+2]);

`ifdef WB_SLAVE_RTY_EN
   assign busy = LOCK_I;
`else
   assign busy = 1'b0;
`endif

   assign mem_we = (state == ST_TERM) && req && in_range && we_q && !busy;

   wb_slave_ram_mem #(.AW(AW)) u_mem (
      .clk_sys (CLK_I),
      .we      (mem_we),
      .sel     (sel_q),
      .addr    (adr_q[AW-1:0]),
      .wdata   (dat_q),
      .rdata   (mem_rdata)
   );

   // New requests are not accepted while a termination strobe is showing, so a master that
   // still holds STB_I during its ACK cycle is not double-served.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         adr_q    <= '0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         dat_q    <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rty_q    <= 1'b0;
         DAT_O    <= '0;
         TAG_O    <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         rty_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req && !(ack_q || err_q || rty_q)) begin
                  adr_q <= ADR_I[31:2];
                  we_q  <= WE_I;
                  sel_q <= SEL_I;
                  dat_q <= DAT_I;
                  TAG_O <= TAG_I;
                  if (WAIT_STATES > 0) begin
                     state    <= ST_WAIT;
                     wait_cnt <= WAIT_LOAD;
                  end else begin
                     state <= ST_TERM;
                  end
               end
            end
            ST_WAIT: begin
               if (!req) begin
                  state    <= ST_IDLE;
                  wait_cnt <= 4'd0;
               end else if (wait_cnt == 4'd0) begin
                  state <= ST_TERM;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_TERM: begin
               state <= ST_IDLE;
               if (req) begin
                  if (busy) begin
                     rty_q <= 1'b1;
                  end else if (!in_range) begin
                     err_q <= 1'b1;
                  end else begin
                     ack_q <= 1'b1;
                     if (!we_q) begin
                        DAT_O <= mem_rdata;
                     end
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ACK_O = ack_q;
   assign ERR_O = err_q;
   assign RTY_O = rty_q;

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram: one instance with WAIT_STATES=1, one with WAIT_STATES=3.
`timescale 1ns/1ps
module tb_wb_slave_ram;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  cyc = '0;
   logic [1:0]  stb = '0;
   logic [1:0]  we = '0;
`ifdef WB_SLAVE_RTY_EN
   logic [1:0]  lock = '0;
`endif
   logic [31:0] adr [2];
   logic [31:0] wdat [2];
   logic [31:0] rdat [2];
   logic [3:0]  sel [2];
   logic [3:0]  tag_i [2];
   logic [3:0]  tag_o [2];
   logic [1:0]  ack;
   logic [1:0]  err;
   logic [1:0]  rty;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   wb_slave_ram #(.AW(6), .BASE(32'h4000_0000), .WAIT_STATES(1)) u_ws1 (
      .CLK_I (clk), .RST_I (rst_n), .CYC_I (cyc[0]), .STB_I (stb[0]), .WE_I (we[0]),
      .ADR_I (adr[0]), .SEL_I (sel[0]), .DAT_I (wdat[0]), .TAG_I (tag_i[0]),
`ifdef WB_SLAVE_RTY_EN
      .LOCK_I (lock[0]),
`endif
      .DAT_O (rdat[0]), .ACK_O (ack[0]), .ERR_O (err[0]), .RTY_O (rty[0]), .TAG_O (tag_o[0])
   );

   wb_slave_ram #(.AW(6), .BASE(32'h4000_0000), .WAIT_STATES(3)) u_ws3 (
      .CLK_I (clk), .RST_I (rst_n), .CYC_I (cyc[1]), .STB_I (stb[1]), .WE_I (we[1]),
      .ADR_I (adr[1]), .SEL_I (sel[1]), .DAT_I (wdat[1]), .TAG_I (tag_i[1]),
`ifdef WB_SLAVE_RTY_EN
      .LOCK_I (lock[1]),
`endif
      .DAT_O (rdat[1]), .ACK_O (ack[1]), .ERR_O (err[1]), .RTY_O (rty[1]), .TAG_O (tag_o[1])
   );

   // lat = edges after the request edge until a termination is visible; -1 on timeout.
   // term = {rty, err, ack} at that point.
   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] dv, input logic [3:0] t,
                       output int lat, output logic [2:0] term, output logic [31:0] rd,
                       output logic [3:0] tg);
      @(negedge clk);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = dv; tag_i[d] = t;
      lat = -1; term = 3'b000; rd = '0; tg = '0;
      for (int n = 1; n <= 24; n++) begin
         @(negedge clk);
         if (ack[d] || err[d] || rty[d]) begin
            lat  = n - 1;
            term = {rty[d], err[d], ack[d]};
            rd   = rdat[d];
            tg   = tag_o[d];
            break;
         end
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         total++;
         if ({ack[d], err[d], rty[d]} !== 3'b000) $display("FAIL reset_term[%0d] got %b want 000", d, {ack[d], err[d], rty[d]});
         else passed++;
         total++;
         if (rdat[d] !== 32'h0 || tag_o[d] !== 4'h0) $display("FAIL reset_data[%0d] got %h/%h want 0/0", d, rdat[d], tag_o[d]);
         else passed++;
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      int lat; logic [2:0] term; logic [31:0] rd; logic [3:0] tg;
      xfer(0, 1'b1, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF, 4'h3, lat, term, rd, tg);
      total++;
      if (lat !== 2 || term !== 3'b001) $display("FAIL wr_ack lat=%0d term=%b want lat=2 term=001", lat, term);
      else passed++;
      total++;
      if (tg !== 4'h3) $display("FAIL wr_tag got %h want 3", tg);
      else passed++;
      xfer(0, 1'b0, 32'h4000_0010, 4'hF, 32'h0, 4'hA, lat, term, rd, tg);
      total++;
      if (lat !== 2 || term !== 3'b001) $display("FAIL rd_ack lat=%0d term=%b want lat=2 term=001", lat, term);
      else passed++;
      total++;
      if (rd !== 32'hDEAD_BEEF || tg !== 4'hA) $display("FAIL rd_data got %h/%h want deadbeef/a", rd, tg);
      else passed++;
      @(negedge clk);
      total++;
      if (ack[0] !== 1'b0 || rdat[0] !== 32'hDEAD_BEEF) $display("FAIL dat_hold ack=%b dat=%h want 0/deadbeef", ack[0], rdat[0]);
      else passed++;
   endtask

   task automatic test_byte_lanes();
      int lat; logic [2:0] term; logic [31:0] rd; logic [3:0] tg;
      xfer(0, 1'b1, 32'h4000_0020, 4'hF, 32'h1122_3344, 4'h1, lat, term, rd, tg);
      xfer(0, 1'b1, 32'h4000_0020, 4'b0101, 32'hAABB_CCDD, 4'h2, lat, term, rd, tg);
      xfer(0, 1'b0, 32'h4000_0022, 4'h0, 32'h0, 4'h4, lat, term, rd, tg);
      total++;
      if (term !== 3'b001 || rd !== 32'h11BB_33DD) $display("FAIL byte_lanes got %h term=%b want 11bb33dd term=001", rd, term);
      else passed++;
      xfer(0, 1'b1, 32'h4000_0020, 4'h0, 32'hFFFF_FFFF, 4'h5, lat, term, rd, tg);
      total++;
      if (lat !== 2 || term !== 3'b001) $display("FAIL sel0_ack lat=%0d term=%b want lat=2 term=001", lat, term);
      else passed++;
      xfer(0, 1'b0, 32'h4000_0020, 4'hF, 32'h0, 4'h6, lat, term, rd, tg);
      total++;
      if (rd !== 32'h11BB_33DD) $display("FAIL sel0_nowrite got %h want 11bb33dd", rd);
      else passed++;
   endtask

   task automatic test_out_of_range();
      int lat; logic [2:0] term; logic [31:0] rd; logic [3:0] tg;
      xfer(0, 1'b1, 32'h4000_0000, 4'hF, 32'h0123_4567, 4'h1, lat, term, rd, tg);
      xfer(0, 1'b0, 32'h4000_0100, 4'hF, 32'h0, 4'h7, lat, term, rd, tg);
      total++;
      if (lat !== 2 || term !== 3'b010) $display("FAIL oor_err lat=%0d term=%b want lat=2 term=010", lat, term);
      else passed++;
      total++;
      if (rd !== 32'h11BB_33DD) $display("FAIL oor_dat got %h want 11bb33dd", rd);
      else passed++;
      @(negedge clk);
      total++;
      if (err[0] !== 1'b0) $display("FAIL oor_pulse err=%b want 0", err[0]);
      else passed++;
      xfer(0, 1'b1, 32'h4000_0100, 4'hF, 32'hFFFF_FFFF, 4'h8, lat, term, rd, tg);
      xfer(0, 1'b0, 32'h4000_0000, 4'hF, 32'h0, 4'h9, lat, term, rd, tg);
      total++;
      if (rd !== 32'h0123_4567) $display("FAIL oor_nowrap got %h want 01234567", rd);
      else passed++;
   endtask

   task automatic test_abort();
      int lat; logic [2:0] term; logic [31:0] rd; logic [3:0] tg; logic seen;
      xfer(1, 1'b1, 32'h4000_0008, 4'hF, 32'hCAFE_F00D, 4'hC, lat, term, rd, tg);
      total++;
      if (lat !== 4 || term !== 3'b001) $display("FAIL ws3_ack lat=%0d term=%b want lat=4 term=001", lat, term);
      else passed++;
      @(negedge clk);
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h4000_0008; sel[1] = 4'hF;
      wdat[1] = 32'h1234_5678; tag_i[1] = 4'hD;
      repeat (2) @(negedge clk);
      cyc[1] = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ack[1] || err[1] || rty[1]) seen = 1'b1;
      end
      stb[1] = 1'b0;
      total++;
      if (seen !== 1'b0) $display("FAIL abort_noterm got %b want 0", seen);
      else passed++;
      xfer(1, 1'b0, 32'h4000_0008, 4'hF, 32'h0, 4'hE, lat, term, rd, tg);
      total++;
      if (term !== 3'b001 || rd !== 32'hCAFE_F00D) $display("FAIL abort_nowrite got %h term=%b want cafef00d term=001", rd, term);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int lat; logic [2:0] term; logic [31:0] rd; logic [3:0] tg;
      xfer(0, 1'b1, 32'h4000_00FC, 4'hF, 32'h0000_00A5, 4'h1, lat, term, rd, tg);
      xfer(0, 1'b1, 32'h4000_00F8, 4'b1000, 32'h7700_0000, 4'h2, lat, term, rd, tg);
      xfer(0, 1'b0, 32'h4000_00FC, 4'hF, 32'h0, 4'h3, lat, term, rd, tg);
      total++;
      if (lat !== 2 || rd !== 32'h0000_00A5) $display("FAIL b2b_top got %h lat=%0d want 000000a5 lat=2", rd, lat);
      else passed++;
   endtask

`ifdef WB_SLAVE_RTY_EN
   task automatic test_retry();
      int lat; logic [2:0] term; logic [31:0] rd; logic [3:0] tg;
      xfer(0, 1'b1, 32'h4000_0040, 4'hF, 32'h0, 4'h1, lat, term, rd, tg);
      lock[0] = 1'b1;
      xfer(0, 1'b1, 32'h4000_0040, 4'hF, 32'h5555_5555, 4'h2, lat, term, rd, tg);
      lock[0] = 1'b0;
      total++;
      if (lat !== 2 || term !== 3'b100) $display("FAIL retry_rty lat=%0d term=%b want lat=2 term=100", lat, term);
      else passed++;
      xfer(0, 1'b0, 32'h4000_0040, 4'hF, 32'h0, 4'h3, lat, term, rd, tg);
      total++;
      if (rd !== 32'h0) $display("FAIL retry_nowrite got %h want 0", rd);
      else passed++;
      xfer(0, 1'b1, 32'h4000_0040, 4'hF, 32'h5555_5555, 4'h4, lat, term, rd, tg);
      total++;
      if (term !== 3'b001) $display("FAIL retry_ack term=%b want 001", term);
      else passed++;
      xfer(0, 1'b0, 32'h4000_0040, 4'hF, 32'h0, 4'h5, lat, term, rd, tg);
      total++;
      if (rd !== 32'h5555_5555) $display("FAIL retry_data got %h want 55555555", rd);
      else passed++;
   endtask
`endif

   task automatic test_reset_mid_write();
      int lat; logic [2:0] term; logic [31:0] rd; logic [3:0] tg;
      xfer(0, 1'b1, 32'h4000_0030, 4'hF, 32'h0BAD_F00D, 4'h6, lat, term, rd, tg);
      xfer(0, 1'b0, 32'h4000_0030, 4'hF, 32'h0, 4'h7, lat, term, rd, tg);
      @(negedge clk);
      cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h4000_0030; sel[0] = 4'hF;
      wdat[0] = 32'hFFFF_0000; tag_i[0] = 4'hB;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({ack[0], err[0], rty[0]} !== 3'b000 || rdat[0] !== 32'h0 || tag_o[0] !== 4'h0)
         $display("FAIL rst_async term=%b dat=%h tag=%h want 000/0/0", {ack[0], err[0], rty[0]}, rdat[0], tag_o[0]);
      else passed++;
      cyc[0] = 1'b0; stb[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      xfer(0, 1'b0, 32'h4000_0030, 4'hF, 32'h0, 4'h8, lat, term, rd, tg);
      total++;
      if (term !== 3'b001 || rd !== 32'h0BAD_F00D) $display("FAIL rst_nowrite got %h term=%b want 0badf00d term=001", rd, term);
      else passed++;
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         adr[d] = '0; wdat[d] = '0; sel[d] = '0; tag_i[d] = '0;
      end
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_out_of_range();
      test_abort();
      test_back_to_back();
`ifdef WB_SLAVE_RTY_EN
      test_retry();
`endif
      test_reset_mid_write();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/wb_slave_ram.md
WB_SLAVE_RAM -- requirements
Module: wb_slave_ram

Interface
REQ-001 AW, default 6, word-address width; memory depth is 2**AW 32-bit words.
REQ-002 BASE, default 32'h4000_0000, base byte address; must be aligned to 4*2**AW.
REQ-003 WAIT_STATES, default 1, number of wait cycles inserted before termination; legal range 0..15.
REQ-004 CLK_I  in  1  single clock; all logic on rising edge.
REQ-005 RST_I  in  1  asynchronous, active-low reset.
REQ-006 CYC_I  in  1  bus cycle valid.
REQ-007 STB_I  in  1  strobe; a transfer is requested when CYC_I&STB_I.
REQ-008 WE_I  in  1  1=write, 0=read.
REQ-009 ADR_I  in  32  byte address; bits [1:0] are ignored.
REQ-010 SEL_I  in  4  byte lane enables, little endian (SEL_I[0] = DAT[7:0]).
REQ-011 DAT_I  in  32  write data.
REQ-012 TAG_I  in  4  request tag.
REQ-013 DAT_O  out  32  read data.
REQ-014 ACK_O / ERR_O / RTY_O  out  1 each  cycle termination strobes.
REQ-015 TAG_O  out  4  tag captured with the request.
REQ-016 LOCK_I  in  1  busy request input; present only with WB_SLAVE_RTY_EN.

Function
REQ-017 FSM states: IDLE, WAIT, TERM; state encoding comes from wb_pkg.
REQ-018 IDLE: on CYC_I&STB_I, capture ADR_I, WE_I, SEL_I, DAT_I, TAG_I; go to WAIT if WAIT_STATES>0, else TERM; load wait counter with WAIT_STATES-1.
REQ-019 WAIT: decrement the counter each cycle; go to TERM in the cycle after the counter reads 0.
REQ-020 TERM: assert exactly one of ACK_O/ERR_O/RTY_O for exactly one cycle, then return to IDLE; there is always at least one IDLE cycle between terminations.
REQ-021 In-range test: captured ADR[31:AW+2] == BASE[31:AW+2]; an out-of-range request terminates with ERR_O, with no memory access and DAT_O unchanged.
REQ-022 Request-to-termination latency is WAIT_STATES+1 cycles, measured from the request edge to the edge at which the termination is visible.
REQ-023 An in-range write updates only the bytes whose SEL bit is set, on the TERM edge.
REQ-024 An in-range read drives DAT_O with the word at ADR[AW+1:2] in the same cycle as ACK_O; unselected lanes are still driven with memory contents.
REQ-025 DAT_O holds its last value whenever ACK_O is low.
REQ-026 Abort: if CYC_I or STB_I drops while in WAIT or TERM, go to IDLE on the next edge with no termination, no write, and no DAT_O change.
REQ-027 SEL_I=4'b0000 with WE_I=1 is acknowledged normally and modifies no bytes.
REQ-028 Address wrap-around is impossible: the index is ADR[AW+1:2] only, with no carry into higher bits.

Reset
REQ-029 While RST_I=0: FSM in IDLE, wait counter 0, ACK_O=ERR_O=RTY_O=0, DAT_O=0, TAG_O=0.
REQ-030 Reset asserted mid-cycle aborts the transfer; no write is committed; memory contents are not reset.
REQ-031 Outputs leave their reset values no earlier than the first rising CLK_I after RST_I deasserts.

Configuration
REQ-032 Macro WB_SLAVE_RTY_EN.
- Defined: LOCK_I exists; if LOCK_I=1 on the TERM cycle, terminate with RTY_O instead of ACK_O or ERR_O, with no write and no DAT_O update.
- Undefined: LOCK_I is absent and RTY_O is tied to 0.

Structure
REQ-033 Package wb_pkg holds:
- FSM state typedef;
- data width constant (32), SEL width (4), TAG width (4);
- the lane-mask helper used for byte-enable writes.
REQ-034 The byte-enable storage array is a sub-module, wb_slave_ram_mem: 2**AW x 32 with 4 byte write enables and an asynchronous read port; the control FSM stays in wb_slave_ram.

Verification
REQ-035 Write then read, WAIT_STATES=1:
- Write 32'hDEAD_BEEF to 32'h4000_0010, SEL=4'hF, then read the same address.
- Required: ACK_O 2 cycles after each request; read DAT_O=32'hDEAD_BEEF; TAG_O echoes TAG_I.
REQ-036 Byte lanes:
- Write 32'h1122_3344 (SEL=4'hF), then 32'hAABB_CCDD with SEL=4'b0101, then read.
- Required: DAT_O=32'h11BB_33DD.
REQ-037 Out of range:
- Read 32'h4000_0100 (AW=6).
- Required: ERR_O for one cycle, ACK_O=0, DAT_O unchanged.
REQ-038 Abort:
- Assert STB_I, then drop CYC_I during WAIT (WAIT_STATES=3).
- Required: no termination, and a subsequent read shows the memory location unchanged.
REQ-039 Retry (macro defined):
- LOCK_I=1 during a write of 32'h5555_5555.
- Required: RTY_O pulse and no write; a retry with LOCK_I=0 gets ACK_O and the data is stored.
REQ-040 Reset mid-write:
- Pull RST_I low during WAIT.
- Required: all outputs 0 immediately (asynchronously); the target word keeps its previous value.
